// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: turns raw vehicle-loop inputs for streets A and B into the
// TA/TB traffic-present signals for the light controller. Each street is synchronized,
// debounced and edge-detected into arrivals; a saturating queue counter is drained while
// that street's green lamp is lit.
// Optional stuck-loop detection is compiled in with `define SENSOR_STUCK_DETECT_EN.
// Street A lives in index 0 of every per-street vector/array, street B in index 1.
module traffic_sensor_conditioner #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned DRAIN    = 8,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned STUCK    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             loop_a,
    input  logic             loop_b,
    input  logic             GA,
    input  logic             GB,
    output logic             TA,
    output logic             TB,
    output logic [CNT_W-1:0] qa,
    output logic [CNT_W-1:0] qb,
    output logic             fault_a,
    output logic             fault_b
);

    localparam int unsigned DbW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned DrW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [DbW-1:0]   DbLast = DbW'(DEBOUNCE - 1);
    localparam logic [DrW-1:0]   DrLast = DrW'(DRAIN - 1);
    localparam logic [CNT_W-1:0] QMax   = '1;

    // Reject degenerate configurations at elaboration.
    if (DEBOUNCE < 1 || DRAIN < 1 || STUCK < 1 || CNT_W < 1) begin : g_param_check
        $error("traffic_sensor_conditioner: parameters must all be >= 1");
    end

    logic [1:0] loop_raw;
    logic [1:0] green;

    assign loop_raw = {loop_b, loop_a};
    assign green    = {GB, GA};

    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] deb_q, deb_d;
    logic [1:0] deb_prev_q, deb_prev_d;
    logic [DbW-1:0]   db_cnt_q [2];
    logic [DbW-1:0]   db_cnt_d [2];
    logic [DrW-1:0]   dr_cnt_q [2];
    logic [DrW-1:0]   dr_cnt_d [2];
    logic [CNT_W-1:0] queue_q  [2];
    logic [CNT_W-1:0] queue_d  [2];

    logic [1:0] arr;
    logic [1:0] dep;
    logic [1:0] fault;

    // Arrival is a rising edge of the debounced loop state; falling edges are ignored.
    assign arr = deb_q & ~deb_prev_q;

    // Synchronizer and debouncer next state.
    always_comb begin
        sync1_d    = loop_raw;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            // Any agreeing sample restarts the count; the DEBOUNCE-th disagreeing one flips.
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    // Drain timer: runs only while green and the queue is non-empty.
    always_comb begin
        dep = '0;
        for (int i = 0; i < 2; i++) begin
            dr_cnt_d[i] = '0;
            if (green[i] && (queue_q[i] != '0)) begin
                if (dr_cnt_q[i] == DrLast) begin
                    dep[i] = 1'b1;
                end else begin
                    dr_cnt_d[i] = dr_cnt_q[i] + DrW'(1);
                end
            end
        end
    end

    // Queue counter: saturating increment on arrival, decrement on departure.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            queue_d[i] = queue_q[i];
            unique case ({arr[i], dep[i]})
                2'b10: if (queue_q[i] != QMax) queue_d[i] = queue_q[i] + CNT_W'(1);
                2'b01: queue_d[i] = queue_q[i] - CNT_W'(1);
                default: queue_d[i] = queue_q[i];
            endcase
        end
    end

    // State registers for synchronizer, debouncer, drain timer and queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
                dr_cnt_q[i] <= '0;
                queue_q[i]  <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                dr_cnt_q[i] <= dr_cnt_d[i];
                queue_q[i]  <= queue_d[i];
            end
        end
    end

`ifdef SENSOR_STUCK_DETECT_EN
    localparam int unsigned StW = $clog2(STUCK + 1);
    localparam logic [StW-1:0] StLim = StW'(STUCK);

    logic [StW-1:0] stuck_q [2];
    logic [StW-1:0] stuck_d [2];
    logic [1:0]     fault_q, fault_d;

    // Stuck counter: consecutive debounced-high cycles, holds at the limit; fault is sticky.
    always_comb begin
        fault_d = fault_q;
        for (int i = 0; i < 2; i++) begin
            stuck_d[i] = '0;
            if (deb_q[i]) begin
                stuck_d[i] = (stuck_q[i] == StLim) ? stuck_q[i] : stuck_q[i] + StW'(1);
            end
            if (stuck_d[i] == StLim) begin
                fault_d[i] = 1'b1;
            end
        end
    end

    // Stuck counter and fault flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= '0;
            for (int i = 0; i < 2; i++) begin
                stuck_q[i] <= '0;
            end
        end else begin
            fault_q <= fault_d;
            for (int i = 0; i < 2; i++) begin
                stuck_q[i] <= stuck_d[i];
            end
        end
    end

    assign fault = fault_q;
`else
    assign fault = '0;
`endif

    assign qa      = queue_q[0];
    assign qb      = queue_q[1];
    assign fault_a = fault[0];
    assign fault_b = fault[1];
    assign TA      = (queue_q[0] != '0) | fault[0];
    assign TB      = (queue_q[1] != '0) | fault[1];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Scoreboard bench for traffic_sensor_conditioner: stimulus pushes each expected output
// change (cycle stamp plus values); a negedge monitor pops and compares on every change.
module tb_traffic_sensor_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       loop_a, loop_b, GA, GB;
    logic       TA, TB, fault_a, fault_b;
    logic [3:0] qa, qb;

    traffic_sensor_conditioner #(
        .DEBOUNCE(4),
        .DRAIN   (8),
        .CNT_W   (4),
        .STUCK   (1024)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .loop_a (loop_a),
        .loop_b (loop_b),
        .GA     (GA),
        .GB     (GB),
        .TA     (TA),
        .TB     (TB),
        .qa     (qa),
        .qb     (qb),
        .fault_a(fault_a),
        .fault_b(fault_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       c;
        logic [3:0] a;
        logic [3:0] b;
        logic     ta;
        logic     tb;
        logic     fa;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0] xa = 4'd0;
    logic [3:0] xb = 4'd0;

    function automatic void push(int c, logic [3:0] a, logic [3:0] b, logic f);
        exp_t e;
        e.c  = c;
        e.a  = a;
        e.b  = b;
        e.fa = f;
        e.ta = (a != 4'd0) | f;
        e.tb = (b != 4'd0);
        sbq.push_back(e);
    endfunction

    // Monitor: every change of the output vector must match the next scoreboard entry.
    logic [11:0] prev = '0;
    logic [11:0] cur;
    exp_t        me;
    always @(negedge clk) begin
        cur = {qa, qb, TA, TB, fault_a, fault_b};
        if (cur !== prev) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got qa=%0d qb=%0d TA=%b TB=%b fa=%b fb=%b",
                         cyc, qa, qb, TA, TB, fault_a, fault_b);
            end else begin
                me = sbq.pop_front();
                if (me.c != cyc || qa !== me.a || qb !== me.b || TA !== me.ta ||
                    TB !== me.tb || fault_a !== me.fa || fault_b !== 1'b0) begin
                    errors++;
                    $display("FAIL change cyc=%0d got qa=%0d qb=%0d TA=%b TB=%b fa=%b fb=%b; want cyc=%0d qa=%0d qb=%0d TA=%b TB=%b fa=%b fb=0",
                             cyc, qa, qb, TA, TB, fault_a, fault_b,
                             me.c, me.a, me.b, me.ta, me.tb, me.fa);
                end
            end
            prev = cur;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_now(input string name, input logic [11:0] want);
        checks++;
        if ({qa, qb, TA, TB, fault_a, fault_b} !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h want %h", name, cyc,
                     {qa, qb, TA, TB, fault_a, fault_b}, want);
        end
    endtask

    // One vehicle: loop high 10 cycles, then low long enough to debounce back to 0.
    task automatic car(input bit st);
        int c;
        c = cyc;
        if (!st) begin
            loop_a = 1'b1;
            if (xa != 4'd15) begin
                xa = xa + 4'd1;
                push(c + 7, xa, xb, 1'b0);
            end
        end else begin
            loop_b = 1'b1;
            if (xb != 4'd15) begin
                xb = xb + 4'd1;
                push(c + 7, xa, xb, 1'b0);
            end
        end
        step(10);
        loop_a = 1'b0;
        loop_b = 1'b0;
        step(10);
    endtask

    int g;
    int c;

    initial begin
        rst = 1'b0; loop_a = 1'b0; loop_b = 1'b0; GA = 1'b0; GB = 1'b0;

        // Reset held with loops toggling: everything stays cleared.
        for (int i = 0; i < 8; i++) begin
            loop_a = i[0];
            loop_b = ~i[0];
            step(1);
            check_now("reset_hold", 12'h000);
        end
        loop_a = 1'b0; loop_b = 1'b0;
        rst = 1'b1;
        step(20);
        check_now("after_release", 12'h000);

        // Single car on A, increment exactly 7 edges after the input rises; two more to qa=3.
        car(1'b0);
        check_now("single_car_hold", {4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        car(1'b0);
        car(1'b0);

        // Glitches on B: 3-cycle pulse, and 3-1-3 pattern with one agreeing sample between.
        loop_b = 1'b1; step(3); loop_b = 1'b0; step(15);
        loop_b = 1'b1; step(3); loop_b = 1'b0; step(1);
        loop_b = 1'b1; step(3); loop_b = 1'b0; step(15);
        check_now("glitch_reject", {4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});

        // Drain qa=3 with GA held: 2, 1, 0 at 8-cycle spacing.
        g = cyc;
        GA = 1'b1;
        push(g + 8, 4'd2, 4'd0, 1'b0);
        push(g + 16, 4'd1, 4'd0, 1'b0);
        push(g + 24, 4'd0, 4'd0, 1'b0);
        step(30);
        GA = 1'b0;
        xa = 4'd0;

        // Arrival coinciding with a departure leaves qa unchanged.
        car(1'b0);
        car(1'b0);
        g = cyc;
        GA = 1'b1;
        push(g + 8, 4'd1, 4'd0, 1'b0);
        push(g + 24, 4'd0, 4'd0, 1'b0);
        step(9);
        loop_a = 1'b1;
        step(10);
        loop_a = 1'b0;
        step(20);
        GA = 1'b0;
        xa = 4'd0;

        // Saturation: 17 arrivals on B stop at 15.
        for (int i = 0; i < 17; i++) car(1'b1);
        check_now("saturate", {4'd0, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0});

        // One drain step on B, then green removed mid-drain loses the partial count.
        g = cyc;
        GB = 1'b1;
        push(g + 8, 4'd0, 4'd14, 1'b0);
        step(8);
        GB = 1'b0;
        step(4);
        g = cyc;
        GB = 1'b1;
        step(5);
        GB = 1'b0;
        step(3);
        GB = 1'b1;
        push(g + 16, 4'd0, 4'd13, 1'b0);
        step(8);
        check_now("mid_drain_loss", {4'd0, 4'd13, 1'b0, 1'b1, 1'b0, 1'b0});

        // Reset mid-debounce on A and mid-drain on B clears everything.
        loop_a = 1'b1;
        step(4);
        rst = 1'b0;
        push(cyc, 4'd0, 4'd0, 1'b0);
        step(3);
        check_now("reset_mid", 12'h000);
        rst = 1'b1;
        GA = 1'b1;
        GB = 1'b0;
        c = cyc;
        // Loop still high: restart from cleared state, then drained to 0 under green.
        push(c + 7, 4'd1, 4'd0, 1'b0);
        push(c + 15, 4'd0, 4'd0, 1'b0);
`ifdef SENSOR_STUCK_DETECT_EN
        push(c + 1030, 4'd0, 4'd0, 1'b1);
`endif
        step(1040);
`ifdef SENSOR_STUCK_DETECT_EN
        check_now("stuck_fault", {4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0});
`else
        check_now("stuck_absent", 12'h000);
`endif
        loop_a = 1'b0;
        rst = 1'b0;
`ifdef SENSOR_STUCK_DETECT_EN
        push(cyc, 4'd0, 4'd0, 1'b0);
`endif
        step(2);
        rst = 1'b1;
        GA = 1'b0;
        step(20);
        check_now("final_state", 12'h000);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL pending_expected got %0d entries left want 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_conditioner.md
# traffic_sensor_conditioner

Front-end stage that turns raw vehicle-loop detector inputs for streets A and B into the clean `TA`/`TB` traffic-present signals consumed directly by `traffic_light_controller`. Each street's loop input is synchronized, debounced and edge-detected into arrival events. A saturating per-street queue counter tracks waiting vehicles and is drained while that street's green lamp (`GA`/`GB`, fed back from the controller) is lit. Optional stuck-loop detection forces the street's traffic signal high as a fail-safe.

## Interface
- `DEBOUNCE`, 4 — consecutive differing synchronized samples required to flip the debounced loop state (≥1)
- `DRAIN`, 8 — cycles of green per vehicle removed from the queue (≥1)
- `CNT_W`, 4 — queue counter width; saturates at 2^CNT_W−1
- `STUCK`, 1024 — consecutive debounced-high cycles that declare a stuck loop (used only with the macro)

- `clk` input 1 — single clock, all state on rising edge
- `rst` input 1 — asynchronous, active-low reset
- `loop_a`, `loop_b` input 1 each — raw asynchronous detector inputs
- `GA`, `GB` input 1 each — green-lamp feedback from the controller
- `TA`, `TB` output 1 each — traffic present, to the controller
- `qa`, `qb` output CNT_W each — registered queue counts
- `fault_a`, `fault_b` output 1 each — sticky stuck-loop flags

## Operation
Identical per street; street A is described.

**Synchronizer**
- Two-flop synchronizer on `loop_a`, producing `s_a`.

**Debouncer**
- Registered `d_a` plus a debounce counter.
- If `s_a == d_a`: the counter clears.
- Otherwise the counter increments. The DEBOUNCE-th consecutive differing sample toggles `d_a` and clears the counter.

**Arrival detection**
- `arr_a` = a one-cycle pulse on a rising edge of `d_a` (registered previous value).
- Falling edges produce no event.

**Drain timer**
- Held at 0 while `GA`=0 or `qa`=0.
- Otherwise counts 0..DRAIN−1. On reaching DRAIN−1 it issues `dep_a` for one cycle and wraps to 0.

**Queue update**, on each edge:
- `arr_a` only: `qa`+1, saturating at max (arrival dropped).
- `dep_a` only: `qa`−1 (`qa`=0 impossible by construction).
- Both together: `qa` unchanged.
- Neither: hold.

**Output**
- `TA` = (`qa` != 0) | `fault_a`.
- Combinational from registers only; no raw input reaches `TA`.

## Timing
**Reset**
- Asserting `rst` low immediately clears all state: synchronizers, `d_a`, counters, `qa`=`qb`=0, `TA`=`TB`=0, `fault_*`=0.
- This holds mid-debounce or mid-drain; no partial state survives.
- After release, behaviour starts from that cleared state on the next edge.

**Latency, loop rising to queue update**
- Loop held stable: `s_a` changes at edge 2, `d_a` at edge 2+DEBOUNCE, `qa`/`TA` at edge 3+DEBOUNCE.
- With DEBOUNCE=4: `qa` increments at edge 7 after the input transition.

**Glitches**
- A pulse shorter than DEBOUNCE synchronized cycles is rejected.
- Any single agreeing sample restarts the debounce count.

**Drain**
- With `GA`=1 held and `qa`=N, the first decrement occurs DRAIN cycles after the timer leaves reset.
- Subsequent decrements occur every DRAIN cycles; `qa` reaches 0 after N·DRAIN cycles.
- `TA` falls in the same cycle `qa` reads 0.

**Green removed mid-drain**
- `GA` falling clears the timer; the partial count is lost.

**Wrap/saturation**
- Counters never wrap.
- `qa` saturates at 2^CNT_W−1; the debounce and drain counters are bounded by their parameters.

## Configuration
Macro `SENSOR_STUCK_DETECT_EN` compiles stuck-loop detection in or out.

**Defined**
- A per-street counter of width $clog2(STUCK+1) counts consecutive cycles with `d_a`=1 and clears when `d_a`=0.
- On reaching STUCK, `fault_a` sets; it is sticky until reset.
- `TA` is forced to 1 while `fault_a`=1.
- Queue and drain logic continue normally.

**Undefined**
- No stuck counters exist.
- `fault_a`/`fault_b` are constant 0.
- `TA` = (`qa` != 0).

## Test plan
- Reset: drive `rst`=0 with loops toggling → all outputs 0. Release, loops low for 20 cycles → outputs remain 0.
- Single car: DEBOUNCE=4, `loop_a` high 10 cycles then low, `GA`=0 → `qa`=1 and `TA`=1 exactly at edge 7; `qa` stays 1 after loop release.
- Glitch reject: `loop_b` high for 3 cycles, then low → `qb`=0 and `TB`=0 throughout.
- Drain and simultaneous events: start from `qa`=3 with `GA`=1 and DRAIN=8 → `qa` reads 2, 1, 0 at 8-cycle spacing and `TA` falls with 0. An arrival coinciding with a `dep_a` cycle → `qa` unchanged that cycle.
- Saturation: CNT_W=4, 17 debounced arrivals with `GA`=0 → `qa`=15. One drain → 14.
- Stuck loop (macro defined, STUCK=1024): `loop_a` held high with `GA`=1 and `qa` drained to 0 → `fault_a`=1 after 1024 debounced-high cycles, `TA`=1 while `qa`=0. `rst` pulse clears the fault. With macro undefined, same stimulus → `fault_a`=0 and `TA`=0.
